booth_r4_mul: RTL and testbench

Parametrised sequential radix-4 Booth multiplier, the successor to the team's 8-bit radix-2 sequential multiplier. It supports any even operand width and selects signed or unsigned operation per transaction. It retires two multiplier bits per clock and reports completion with a start/busy/done handshake. The product output is registered and held between transactions. It sits as an arithmetic slave beside the datapath ALU.

---
 rtl/booth_r4_mul.sv | 133 +++++++++++++
 tb/tb_booth_r4_mul.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_r4_mul.sv
// Sequential radix-4 Booth multiplier, signed/unsigned per transaction.
// Retires two multiplier bits per cycle; start/busy/done handshake with a held product register.
module booth_r4_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   mc,
  input  logic [WIDTH-1:0]   mp,
  input  logic               is_signed,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int W2 = WIDTH + 2;
  localparam int N  = W2 / 2;
  localparam int AW = W2 + 2;
  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_reg, state_next;
  logic [AW-1:0]      acc_reg, acc_next;
  logic [W2-1:0]      q_reg, q_next;
  logic               qm1_reg, qm1_next;
  logic [W2-1:0]      m_reg, m_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [2*WIDTH-1:0] prod_reg, prod_next;
  logic               done_reg, done_next;

  logic [AW-1:0]      m_ext;
  logic [AW-1:0]      pp;
  logic               neg;
  logic [AW-1:0]      sum;
  logic [2:0]         trip;

  // Extension bits for the incoming operands: copies of the MSB in signed mode, zero otherwise.
  logic [1:0]         mc_ext_bits, mp_ext_bits;
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ext
      assign mc_ext_bits[gi] = is_signed & mc[WIDTH-1];
      assign mp_ext_bits[gi] = is_signed & mp[WIDTH-1];
    end
  endgenerate

  assign m_ext = {{2{m_reg[W2-1]}}, m_reg};
  assign trip  = {q_reg[1:0], qm1_reg};

  always_comb begin
    pp  = '0;
    neg = 1'b0;
    case (trip)
      3'b001, 3'b010: pp = m_ext;
      3'b011:         pp = m_ext << 1;
      3'b100: begin
        pp  = m_ext << 1;
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        pp  = m_ext;
        neg = 1'b1;
      end
      default: pp = '0;
    endcase
  end

  // Subtraction folds into the same adder: ~pp plus a carry-in of one.
  assign sum = acc_reg + (neg ? ~pp : pp) + {{(AW-1){1'b0}}, neg};

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    q_next     = q_reg;
    qm1_next   = qm1_reg;
    m_next     = m_reg;
    cnt_next   = cnt_reg;
    prod_next  = prod_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          m_next     = {mc_ext_bits, mc};
          q_next     = {mp_ext_bits, mp};
          acc_next   = '0;
          qm1_next   = 1'b0;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        acc_next = {sum[AW-1], sum[AW-1], sum[AW-1:2]};
        q_next   = {sum[1:0], q_reg[W2-1:2]};
        qm1_next = q_reg[1];
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == CW'(N - 1)) begin
          state_next = IDLE;
          done_next  = 1'b1;
          prod_next  = {acc_next[WIDTH-3:0], q_next};
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      q_reg     <= '0;
      qm1_reg   <= 1'b0;
      m_reg     <= '0;
      cnt_reg   <= '0;
      prod_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      q_reg     <= q_next;
      qm1_reg   <= qm1_next;
      m_reg     <= m_next;
      cnt_reg   <= cnt_next;
      prod_reg  <= prod_next;
      done_reg  <= done_next;
    end
  end

  assign busy = (state_reg == RUN);
  assign done = done_reg;
  assign prod = prod_reg;

endmodule

// File: tb/tb_booth_r4_mul.sv
// Bench for booth_r4_mul: WIDTH=8 and WIDTH=16 instances checked against
// fixed vectors, handshake sequences and an integer-arithmetic reference.
module tb_booth_r4_mul;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st8 = 1'b0, sg8 = 1'b0;
  logic [7:0]  mc8 = '0, mp8 = '0;
  logic        busy8, done8;
  logic [15:0] prod8;
  logic        st16 = 1'b0, sg16 = 1'b0;
  logic [15:0] mc16 = '0, mp16 = '0;
  logic        busy16, done16;
  logic [31:0] prod16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_r4_mul #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .mc(mc8), .mp(mp8),
    .is_signed(sg8), .busy(busy8), .done(done8), .prod(prod8)
  );

  booth_r4_mul #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(st16), .mc(mc16), .mp(mp16),
    .is_signed(sg16), .busy(busy16), .done(done16), .prod(prod16)
  );

  typedef struct {
    logic        w16;
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic cur_busy(input bit w);
    return w ? busy16 : busy8;
  endfunction

  function automatic logic cur_done(input bit w);
    return w ? done16 : done8;
  endfunction

  function automatic logic [31:0] cur_prod(input bit w);
    return w ? prod16 : {16'b0, prod8};
  endfunction

  // Reference: plain integer product of the operands interpreted per mode.
  function automatic logic [31:0] ref_mul(input bit w, input logic [15:0] a, input logic [15:0] b,
                                          input logic s);
    longint x, y, p;
    if (w) begin
      x = longint'(a);
      y = longint'(b);
      if (s && a[15]) x = x - 65536;
      if (s && b[15]) y = y - 65536;
    end else begin
      x = longint'(a[7:0]);
      y = longint'(b[7:0]);
      if (s && a[7]) x = x - 256;
      if (s && b[7]) y = y - 256;
    end
    p = x * y;
    return w ? p[31:0] : {16'b0, p[15:0]};
  endfunction

  task automatic drive_start(input bit w, input logic [15:0] a, input logic [15:0] b, input logic s);
    if (w) begin
      mc16 = a; mp16 = b; sg16 = s; st16 = 1'b1;
    end else begin
      mc8 = a[7:0]; mp8 = b[7:0]; sg8 = s; st8 = 1'b1;
    end
  endtask

  // One full transaction with latency, busy-window and product checks.
  task automatic mul(input bit w, input logic [15:0] a, input logic [15:0] b, input logic s,
                     input logic [31:0] exp, input string name);
    int cyc;
    bit busy_ok;
    @(negedge clk);
    drive_start(w, a, b, s);
    @(posedge clk); #1;
    st8 = 1'b0; st16 = 1'b0;
    chk({name, " busy_after_start"}, {31'b0, cur_busy(w)}, 32'd1);
    cyc = 0;
    busy_ok = 1'b1;
    while (!cur_done(w) && cyc < 30) begin
      if (!cur_busy(w)) busy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, " latency"}, cyc, w ? 32'd9 : 32'd5);
    chk({name, " busy_window"}, {31'b0, busy_ok}, 32'd1);
    chk({name, " busy_at_done"}, {31'b0, cur_busy(w)}, 32'd0);
    chk({name, " prod"}, cur_prod(w), exp);
    $display("txn %s w16=%0d a=%h b=%h s=%0d prod=%h exp=%h lat=%0d",
             name, w, a, b, s, cur_prod(w), exp, cyc);
    @(posedge clk); #1;
    chk({name, " done_pulse"}, {31'b0, cur_done(w)}, 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    int cyc;
    bit held;
    logic [15:0] ra, rb;
    logic rs;

    vecs[0] = '{1'b0, 16'h0080, 16'h0080, 1'b1, 32'h0000_4000};
    vecs[1] = '{1'b0, 16'h0080, 16'h007F, 1'b1, 32'h0000_C080};
    vecs[2] = '{1'b0, 16'h00FF, 16'h00FF, 1'b1, 32'h0000_0001};
    vecs[3] = '{1'b0, 16'h00FF, 16'h00FF, 1'b0, 32'h0000_FE01};
    vecs[4] = '{1'b0, 16'h0080, 16'h0002, 1'b0, 32'h0000_0100};
    vecs[5] = '{1'b0, 16'h0000, 16'h00A5, 1'b0, 32'h0000_0000};
    vecs[6] = '{1'b1, 16'h8000, 16'h8000, 1'b1, 32'h4000_0000};
    vecs[7] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy8", {31'b0, busy8}, 32'd0);
    chk("rst done8", {31'b0, done8}, 32'd0);
    chk("rst prod8", {16'b0, prod8}, 32'd0);
    chk("rst busy16", {31'b0, busy16}, 32'd0);
    chk("rst prod16", prod16, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      mul(vecs[i].w16, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, $sformatf("vec%0d", i));

    // Start during busy is ignored; operand changes mid-run have no effect
    @(negedge clk);
    drive_start(1'b0, 16'd3, 16'd7, 1'b1);
    @(posedge clk); #1;
    st8 = 1'b0;
    @(posedge clk); #1;
    drive_start(1'b0, 16'h11, 16'h22, 1'b1);
    @(posedge clk); #1;
    st8 = 1'b0; mc8 = 8'h55; mp8 = 8'h99; sg8 = 1'b0;
    chk("ignore busy", {31'b0, busy8}, 32'd1);
    cyc = 2;
    while (!done8 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("ignore latency", cyc, 32'd5);
    chk("ignore prod", {16'b0, prod8}, 32'h15);
    $display("txn ignore-start 3x7 prod=%h lat=%0d", prod8, cyc);
    @(posedge clk); #1;
    chk("ignore no_rerun", {31'b0, busy8}, 32'd0);
    chk("ignore done_low", {31'b0, done8}, 32'd0);

    // Back-to-back: next start issued on the done cycle
    @(negedge clk);
    drive_start(1'b0, 16'h80, 16'h7F, 1'b1);
    @(posedge clk); #1;
    st8 = 1'b0;
    cyc = 0;
    while (!done8 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("b2b first prod", {16'b0, prod8}, 32'hC080);
    drive_start(1'b0, 16'h7F, 16'h7F, 1'b1);
    @(posedge clk); #1;
    st8 = 1'b0;
    chk("b2b accepted", {31'b0, busy8}, 32'd1);
    chk("b2b done_drop", {31'b0, done8}, 32'd0);
    cyc = 0;
    held = 1'b1;
    while (!done8 && cyc < 30) begin
      if (prod8 !== 16'hC080) held = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    chk("b2b held", {31'b0, held}, 32'd1);
    chk("b2b latency", cyc, 32'd5);
    chk("b2b second prod", {16'b0, prod8}, 32'h3F01);
    $display("txn back-to-back 7Fx7F prod=%h lat=%0d", prod8, cyc);

    // Reset during step 3 aborts the run
    @(negedge clk);
    drive_start(1'b0, 16'h55, 16'h33, 1'b1);
    @(posedge clk); #1;
    st8 = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("abort busy", {31'b0, busy8}, 32'd0);
    chk("abort prod", {16'b0, prod8}, 32'd0);
    held = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (done8 !== 1'b0) held = 1'b0;
    end
    chk("abort no_done", {31'b0, held}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn reset-abort 55x33");
    mul(1'b0, 16'h55, 16'h33, 1'b1, 32'h10EF, "after_reset");

    // Random operands against the reference, both widths and both modes
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      mul(1'b0, {8'b0, ra[7:0]}, {8'b0, rb[7:0]}, rs, ref_mul(1'b0, ra, rb, rs), $sformatf("r8_%0d", i));
    end
    for (int i = 0; i < 2500; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      mul(1'b1, ra, rb, rs, ref_mul(1'b1, ra, rb, rs), $sformatf("r16_%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
